// File: rtl/mem_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mem_xfer_ctrl
// Summary  : Fills memory A from the input stream, then copies A to B.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_xfer_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic              dataInValid,
  output logic              weA,
  output logic              reA,
  output logic [ADDR_W-1:0] addrA,
  output logic              weB,
  output logic [ADDR_W-1:0] addrB,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_COPY  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_nxt;
  logic [ADDR_W-1:0] r_rd_ptr, w_rd_nxt;
  logic              r_weB;
  logic [ADDR_W-1:0] r_addrB;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_weB    <= 1'b0;
      r_addrB  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      // Read data appears one cycle after reA; an abort squashes that write.
      r_weB    <= reA & ~abort;
      r_addrB  <= addrA;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    weA         = 1'b0;
    reA         = 1'b0;
    addrA       = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_FILL;
          w_wr_nxt    = '0;
        end
      end

      S_FILL: begin
        busy = 1'b1;
        weA  = dataInValid;
        if (dataInValid) addrA = r_wr_ptr;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_wr_nxt    = '0;
          w_rd_nxt    = '0;
        end else if (dataInValid) begin
          w_wr_nxt = r_wr_ptr + 1'b1;
          if (r_wr_ptr == c_last) begin
            w_state_nxt = S_COPY;
            w_rd_nxt    = '0;
          end
        end
      end

      S_COPY: begin
        busy  = 1'b1;
        reA   = 1'b1;
        addrA = r_rd_ptr;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_wr_nxt    = '0;
          w_rd_nxt    = '0;
        end else begin
          w_rd_nxt = r_rd_ptr + 1'b1;
          if (r_rd_ptr == c_last) w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_wr_nxt    = '0;
          w_rd_nxt    = '0;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign weB   = r_weB;
  assign addrB = r_addrB;

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_xfer_ctrl
// Summary  : Scoreboard bench for mem_xfer_ctrl with a behavioural A/B datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_xfer_ctrl;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              dataInValid = 1'b0;
  logic              weA, reA, weB, busy, done;
  logic [ADDR_W-1:0] addrA, addrB;

  logic [31:0] din = '0;
  logic [31:0] memA [DEPTH];
  logic [31:0] memB [DEPTH];
  logic [31:0] rd_q = '0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mem_xfer_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .start       (start),
    .abort       (abort),
    .dataInValid (dataInValid),
    .weA         (weA),
    .reA         (reA),
    .addrA       (addrA),
    .weB         (weB),
    .addrB       (addrB),
    .busy        (busy),
    .done        (done)
  );

  // Datapath: memory A (sync read), memory B written with A read data.
  always @(posedge clk) begin
    if (weA) memA[addrA] <= din;
    if (reA) rd_q <= memA[addrA];
    if (weB) memB[addrB] <= rd_q;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (Reset && weB) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_weB_addr", {29'b0, addrB}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check_val("sb_addrB", {29'b0, addrB}, {29'b0, mon_e.addr});
        check_val("sb_dataB", rd_q, mon_e.data);
      end
    end
  end

  task automatic idle_step();
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; dataInValid = 1'b0;
  endtask

  // Runs one transfer starting at cycle 0; returns the cycle done was seen (-1 if never).
  task automatic xfer(input bit toggle, input bit spurious, input int abort_c,
                      input int keep, output int done_c);
    int  vcnt;
    int  lastv;
    bit  fill;
    vcnt   = 0;
    lastv  = -100;
    done_c = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      start       = (c == 0) || (spurious && (c == 3 || c == 18));
      abort       = (c == abort_c);
      dataInValid = 1'b0;
      fill        = (c > 0) && (vcnt < DEPTH);
      if (fill && (!toggle || (c % 2 == 1))) begin
        dataInValid = 1'b1;
        din = $urandom;
        if (vcnt < keep) sb.push_back('{addr: ADDR_W'(vcnt), data: din});
        vcnt++;
        lastv = c;
      end
      @(negedge clk);
      if (fill) begin
        check_val("fill_weA", {31'b0, weA}, {31'b0, dataInValid});
        if (dataInValid) check_val("fill_addrA", {29'b0, addrA}, vcnt - 1);
      end
      if (vcnt == DEPTH && c == lastv + 1) begin
        check_val("copy_first_reA", {31'b0, reA}, 1);
        check_val("copy_first_addrA", {29'b0, addrA}, 0);
      end
      if (c == abort_c) begin
        check_val("abort_cyc_reA", {31'b0, reA}, 1);
        check_val("abort_cyc_addrA", {29'b0, addrA}, abort_c - lastv - 1);
      end
      if (abort_c >= 0 && c == abort_c + 1) begin
        check_val("post_abort_reA", {31'b0, reA}, 0);
        check_val("post_abort_weB", {31'b0, weB}, 0);
        check_val("post_abort_busy", {31'b0, busy}, 0);
        check_val("post_abort_done", {31'b0, done}, 0);
      end
      if (done) begin
        done_c = c;
        break;
      end
      if (abort_c >= 0 && c == abort_c + 3) break;
    end
    idle_step();
  endtask

  initial begin
    logic [31:0] words [DEPTH];
    int dc;
    int dc_before;

    // Reset held low with start/valid asserted.
    start = 1'b1; dataInValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_weA", {31'b0, weA}, 0);
      check_val("rst_reA", {31'b0, reA}, 0);
      check_val("rst_weB", {31'b0, weB}, 0);
      check_val("rst_busy", {31'b0, busy}, 0);
      check_val("rst_done", {31'b0, done}, 0);
      check_val("rst_addrA", {29'b0, addrA}, 0);
      check_val("rst_addrB", {29'b0, addrB}, 0);
    end
    start = 1'b0; dataInValid = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst_busy", {31'b0, busy}, 0);
      check_val("post_rst_weA", {31'b0, weA}, 0);
    end

    // Nominal transfer, cycle-exact output sequence.
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      start       = (c == 0);
      dataInValid = (c >= 1 && c <= 8);
      if (dataInValid) begin
        din = $urandom;
        words[c-1] = din;
        sb.push_back('{addr: ADDR_W'(c - 1), data: din});
      end
      @(negedge clk);
      check_val("nom_weA", {31'b0, weA}, (c >= 1 && c <= 8));
      check_val("nom_reA", {31'b0, reA}, (c >= 9 && c <= 16));
      check_val("nom_addrA", {29'b0, addrA},
                (c >= 1 && c <= 8) ? c - 1 : (c >= 9 && c <= 16) ? c - 9 : 0);
      check_val("nom_weB", {31'b0, weB}, (c >= 10 && c <= 17));
      if (c >= 10 && c <= 17) check_val("nom_addrB", {29'b0, addrB}, c - 10);
      check_val("nom_busy", {31'b0, busy}, (c >= 1 && c <= 17));
      check_val("nom_done", {31'b0, done}, (c == 18));
    end
    start = 1'b0; dataInValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) check_val("nom_memB", memB[i], words[i]);

    // Valid toggling 1,0,1,0...: last valid at cycle 15, done at 25.
    xfer(1'b1, 1'b0, -1, DEPTH, dc);
    check_val("toggle_done_cycle", dc, 25);

    // Abort while issuing rd_ptr=4; writes 0..3 reach B, addr 4 is squashed.
    dc_before = done_cnt;
    xfer(1'b0, 1'b0, 13, 4, dc);
    check_val("abort_no_done_seen", dc, -1);
    check_val("abort_done_count", done_cnt - dc_before, 0);
    xfer(1'b0, 1'b0, -1, DEPTH, dc);
    check_val("restart_done_cycle", dc, 18);

    // start pulsed during FILL and DONE: exactly one done.
    dc_before = done_cnt;
    xfer(1'b0, 1'b1, -1, DEPTH, dc);
    check_val("spurious_done_cycle", dc, 18);
    repeat (25) @(negedge clk);
    check_val("spurious_done_count", done_cnt - dc_before, 1);
    check_val("spurious_idle_busy", {31'b0, busy}, 0);

    // start and abort together in IDLE.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    idle_step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("start_abort_busy", {31'b0, busy}, 0);
      check_val("start_abort_weA", {31'b0, weA}, 0);
    end

    // Asynchronous reset mid-COPY at rd_ptr=5.
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk); #1;
      start       = (c == 0);
      dataInValid = (c >= 1 && c <= 8);
      if (dataInValid) begin
        din = $urandom;
        if (c <= 4) sb.push_back('{addr: ADDR_W'(c - 1), data: din});
      end
    end
    #1;
    check_val("pre_rst_reA", {31'b0, reA}, 1);
    check_val("pre_rst_addrA", {29'b0, addrA}, 5);
    #2;
    Reset = 1'b0;
    #1;
    check_val("async_rst_reA", {31'b0, reA}, 0);
    check_val("async_rst_weB", {31'b0, weB}, 0);
    check_val("async_rst_busy", {31'b0, busy}, 0);
    check_val("async_rst_addrA", {29'b0, addrA}, 0);
    check_val("async_rst_addrB", {29'b0, addrB}, 0);
    start = 1'b0; dataInValid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("sb_drained_before_rst", sb.size(), 0);
    Reset = 1'b1;
    xfer(1'b0, 1'b0, -1, DEPTH, dc);
    check_val("post_rst_done_cycle", dc, 18);

    repeat (3) @(negedge clk);
    check_val("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
- Sequencing controller for the memory-to-memory transfer datapath.
- On a start pulse, fills source memory A with DEPTH words arriving on the datapath's dataInA bus, qualified by dataInValid.
- Then copies A to destination memory B word by word, pipelined.
- Emits all memory enables and addresses to the datapath; signals completion with a one-cycle done pulse.

Parameters:
ADDR_W, 3, address width of memories A and B
DEPTH, 8, words per transfer; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin a transfer; sampled only in IDLE
abort  input  1  cancel the transfer in progress
dataInValid  input  1  dataInA word is valid this cycle
weA  output  1  write enable, memory A
reA  output  1  read enable, memory A (synchronous read, 1-cycle latency)
addrA  output  ADDR_W  address, memory A
weB  output  1  write enable, memory B (write data = A read data)
addrB  output  ADDR_W  address, memory B
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset low: state=IDLE, wr_ptr=rd_ptr=0, all registered outputs 0, immediately (async). Outputs stay 0 until the first clk edge after Reset goes high.
- States: IDLE, FILL, COPY, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 -> FILL; wr_ptr cleared to 0.
  - abort has priority over start in IDLE.
- FILL:
  - weA = dataInValid (combinational); addrA = wr_ptr.
  - wr_ptr increments only on valid cycles.
  - The valid cycle with wr_ptr=DEPTH-1 writes the last word; next state is COPY, rd_ptr cleared to 0.
  - Gaps in dataInValid stall FILL indefinitely, with no timeout.
- COPY:
  - reA=1 and addrA=rd_ptr every cycle; rd_ptr increments.
  - weB and addrB are reA and addrA registered one cycle: weB(t+1)=reA(t), addrB(t+1)=addrA(t).
  - Issuing rd_ptr=DEPTH-1 -> DRAIN.
- DRAIN: reA=0; weB=1 with addrB=DEPTH-1 (pipelined last write) -> DONE.
- DONE: done=1 for exactly one cycle; busy=0 -> IDLE.
- busy = 1 in FILL, COPY, DRAIN; 0 otherwise.
- weA is 0 outside FILL. reA is 0 outside COPY. weB is 0 except the cycle after each COPY cycle.
- addrA is 0 when neither weA nor reA is asserted.
- abort=1 in FILL, COPY or DRAIN:
  - Next state is IDLE; no done.
  - weA, reA and weB are 0 from the next cycle; a pending pipelined weB is squashed.
  - Pointers are cleared.
- start while busy or in DONE: ignored, not queued.
- Pointers wrap naturally at 2**ADDR_W. Each transfer always begins at address 0.
- Nominal latency: start sampled at cycle 0 with DEPTH back-to-back valids -> done at cycle 2*DEPTH+2.

Test Plan:
1. Reset=0 for 3 cycles with start=1 and dataInValid=1 -> weA=reA=weB=busy=done=0, addrA=addrB=0; no activity after release until a new start.
2. start at cycle 0, dataInValid=1 cycles 1-8:
   - weA=1 with addrA=0..7 in cycles 1-8.
   - reA=1 with addrA=0..7 in cycles 9-16.
   - weB=1 with addrB=0..7 in cycles 10-17.
   - done=1 only in cycle 18; busy=1 in cycles 1-17.
   - Scoreboard: memory B equals the 8 random dataInA words.
3. dataInValid toggles 1,0,1,0,...:
   - weA high only on valid cycles; addrA advances 0..7 only on those cycles.
   - COPY starts the cycle after the 8th valid.
   - Data in B is unchanged versus scenario 2 ordering.
4. abort=1 in the COPY cycle issuing rd_ptr=4:
   - Next cycle IDLE, reA=weB=0 (pending write of addr 4 squashed), busy=0, no done pulse.
   - A following start restarts FILL at addrA=0.
5. start pulsed during FILL and during DONE -> no effect; exactly one done per accepted start. start and abort together in IDLE -> stays IDLE.
6. Reset driven low mid-COPY (rd_ptr=5, not clock-aligned):
   - All outputs 0 within the same cycle.
   - After release, a full transfer completes with done at cycle 2*DEPTH+2 after start.
